// File: rtl/cost_arb_pkg.sv
// Shared types and constants for the cost-ROM arbiter: FSM states, ROM widths,
// burst counter width and the default burst limit.
package cost_arb_pkg;
  localparam int IDX_W         = 3;
  localparam int COST_W        = 7;
  localparam int CNT_W         = 4;
  localparam int MAX_BURST_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;
endpackage

// File: rtl/cost_arb_if.sv
// Requester/ROM side bundle of the cost arbiter. master = requesters plus ROM,
// slave = the arbiter.
interface cost_arb_if;
  import cost_arb_pkg::*;

  logic              req0, req1;
  logic              last0, last1;
  logic [IDX_W-1:0]  W0, J0, W1, J1;
  logic              gnt0, gnt1;
  logic              cvld0, cvld1;
  logic [COST_W-1:0] cost_o;
  logic [IDX_W-1:0]  W, J;
  logic [COST_W-1:0] Cost;

  modport master (
    output req0, req1, last0, last1, W0, J0, W1, J1, Cost,
    input  gnt0, gnt1, cvld0, cvld1, cost_o, W, J
  );

  modport slave (
    input  req0, req1, last0, last1, W0, J0, W1, J1, Cost,
    output gnt0, gnt1, cvld0, cvld1, cost_o, W, J
  );
endinterface

// File: rtl/cost_arb_rr.sv
// Round-robin tie-break: remembers which requester should win the next tie and
// resolves the pick when leaving IDLE.
module cost_arb_rr (
  input  logic clk,
  input  logic rst_n,
  input  logic upd,
  input  logic served,
  input  logic req0,
  input  logic req1,
  output logic pick
);
  logic prio;

  // prio names the requester preferred on a tie; the one just served loses it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   prio <= 1'b0;
    else if (upd) prio <= ~served;
  end

  assign pick = (req0 & req1) ? prio : req1;
endmodule

// File: rtl/cost_arb.sv
// Two-requester arbiter for a shared cost ROM with burst limiting and
// grant-tagged return data. Optional lookup counters under COST_ARB_STATS_EN.
module cost_arb
  import cost_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  cost_arb_if.slave  bus
`ifdef COST_ARB_STATS_EN
  ,
  output logic [15:0] lk_cnt0,
  output logic [15:0] lk_cnt1
`endif
);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  state_t            state;
  logic              gnt0_q, gnt1_q;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              iss0, iss1, granted, serving1;
  logic              req_own, last_own, req_oth;
  logic              hit_max, burst_end, pick;
  logic              pend, owner;
  logic [COST_W-1:0] cost_q;

  assign serving1  = (state == OWN1);
  assign granted   = (state != IDLE);
  assign iss0      = (state == OWN0) & bus.req0;
  assign iss1      = serving1 & bus.req1;
  assign req_own   = serving1 ? bus.req1  : bus.req0;
  assign last_own  = serving1 ? bus.last1 : bus.last0;
  assign req_oth   = serving1 ? bus.req0  : bus.req1;
  assign cnt_nx    = cnt + 1'b1;
  assign hit_max   = (cnt_nx == BURST_MAX);
  assign burst_end = granted & (~req_own | last_own | (hit_max & req_oth));

  cost_arb_rr u_rr (
    .clk    (CLK),
    .rst_n  (RST),
    .upd    (burst_end),
    .served (serving1),
    .req0   (bus.req0),
    .req1   (bus.req1),
    .pick   (pick)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.req0 | bus.req1) begin
            state  <= pick ? OWN1 : OWN0;
            gnt0_q <= ~pick;
            gnt1_q <= pick;
          end
        end
        default: begin
          if (burst_end) begin
            cnt <= '0;
            // hand straight over when the other side is waiting, no bubble
            if (req_oth) begin
              state  <= serving1 ? OWN0 : OWN1;
              gnt0_q <= serving1;
              gnt1_q <= ~serving1;
            end else begin
              state  <= IDLE;
              gnt0_q <= 1'b0;
              gnt1_q <= 1'b0;
            end
          end else if (hit_max) begin
            cnt <= '0;
          end else begin
            cnt <= cnt_nx;
          end
        end
      endcase
    end
  end

  // owner is captured at issue so a grant switch cannot retag in-flight data
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pend   <= 1'b0;
      owner  <= 1'b0;
      cost_q <= '0;
    end else begin
      pend <= iss0 | iss1;
      if (iss0 | iss1) owner  <= iss1;
      if (pend)        cost_q <= bus.Cost;
    end
  end

  assign bus.gnt0   = gnt0_q;
  assign bus.gnt1   = gnt1_q;
  assign bus.cvld0  = pend & ~owner;
  assign bus.cvld1  = pend & owner;
  assign bus.cost_o = pend ? bus.Cost : cost_q;
  assign bus.W      = iss0 ? bus.W0 : (iss1 ? bus.W1 : '0);
  assign bus.J      = iss0 ? bus.J0 : (iss1 ? bus.J1 : '0);

`ifdef COST_ARB_STATS_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lk_cnt0 <= '0;
      lk_cnt1 <= '0;
    end else begin
      if (iss0 && lk_cnt0 != 16'hFFFF) lk_cnt0 <= lk_cnt0 + 16'd1;
      if (iss1 && lk_cnt1 != 16'hFFFF) lk_cnt1 <= lk_cnt1 + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cost_arb.sv
// Directed plus randomized bench for cost_arb against a cycle-level model built
// from the arbitration rules; define COST_ARB_STATS_EN to cover the counters.
module tb_cost_arb;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  cost_arb_if bus ();

`ifdef COST_ARB_STATS_EN
  logic [15:0] lk_cnt0, lk_cnt1;
  cost_arb #(.MAX_BURST(8)) dut (.CLK(CLK), .RST(RST), .bus(bus),
                                 .lk_cnt0(lk_cnt0), .lk_cnt1(lk_cnt1));
`else
  cost_arb #(.MAX_BURST(8)) dut (.CLK(CLK), .RST(RST), .bus(bus));
`endif

  always #5 CLK = ~CLK;

  // ROM model: registered, one cycle latency
  bit rom_mix = 1'b0;
  logic [6:0] rom_q = '0;

  function automatic logic [6:0] rom_f(input logic [2:0] w, input logic [2:0] j);
    int t;
    t = rom_mix ? (int'(w) * 10 + int'(j) * 3) : int'(w) * 10;
    return 7'(t % 128);
  endfunction

  always @(posedge CLK) rom_q <= rom_f(bus.W, bus.J);
  assign bus.Cost = rom_q;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // reference model state: owner -1 = nobody holds the ROM
  int m_own, m_cnt, m_prio, m_pw;
  bit m_pv;
  logic [6:0] m_rom, m_hold;
  int m_lk0, m_lk1;
  bit e_i0, e_i1;
  logic [2:0] e_w, e_j;
  localparam int MB = 8;

  task automatic model_reset();
    m_own = -1; m_cnt = 0; m_prio = 0; m_pv = 0; m_pw = 0;
    m_rom = '0; m_hold = '0; m_lk0 = 0; m_lk1 = 0;
  endtask

  task automatic drive(input bit r0, input int w0, input int j0, input bit l0,
                       input bit r1, input int w1, input int j1, input bit l1);
    bus.req0 = r0; bus.W0 = 3'(w0); bus.J0 = 3'(j0); bus.last0 = l0;
    bus.req1 = r1; bus.W1 = 3'(w1); bus.J1 = 3'(j1); bus.last1 = l1;
  endtask

  // called at posedge+1 with inputs set; lands on the negedge and compares
  task automatic cyc_check();
    #4;
    e_i0 = (m_own == 0) && bus.req0;
    e_i1 = (m_own == 1) && bus.req1;
    e_w  = e_i0 ? bus.W0 : (e_i1 ? bus.W1 : 3'd0);
    e_j  = e_i0 ? bus.J0 : (e_i1 ? bus.J1 : 3'd0);
    chk("gnt0",  16'(bus.gnt0),  16'(m_own == 0));
    chk("gnt1",  16'(bus.gnt1),  16'(m_own == 1));
    chk("W",     16'(bus.W),     16'(e_w));
    chk("J",     16'(bus.J),     16'(e_j));
    chk("cvld0", 16'(bus.cvld0), 16'(m_pv && m_pw == 0));
    chk("cvld1", 16'(bus.cvld1), 16'(m_pv && m_pw == 1));
    chk("cost",  16'(bus.cost_o), 16'(m_pv ? m_rom : m_hold));
`ifdef COST_ARB_STATS_EN
    chk("lk0", lk_cnt0, 16'(m_lk0));
    chk("lk1", lk_cnt1, 16'(m_lk1));
`endif
  endtask

  task automatic cyc_adv();
    bit r[2], l[2], fin;
    int x, o;
    r[0] = bus.req0; r[1] = bus.req1; l[0] = bus.last0; l[1] = bus.last1;
    if (m_pv) m_hold = m_rom;
    m_rom = rom_f(e_w, e_j);
    m_pv  = e_i0 || e_i1;
    m_pw  = e_i1 ? 1 : 0;
    if (e_i0 && m_lk0 < 65535) m_lk0++;
    if (e_i1 && m_lk1 < 65535) m_lk1++;
    if (m_own < 0) begin
      m_cnt = 0;
      if (r[0] && r[1]) m_own = m_prio;
      else if (r[0])    m_own = 0;
      else if (r[1])    m_own = 1;
    end else begin
      x = m_own; o = 1 - x; fin = 0;
      if (!r[x]) fin = 1;
      else begin
        m_cnt++;
        if (l[x]) fin = 1;
        else if (m_cnt == MB) begin
          if (r[o]) fin = 1; else m_cnt = 0;
        end
      end
      if (fin) begin
        m_prio = o;
        m_cnt  = 0;
        m_own  = r[o] ? o : -1;
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic cyc();
    cyc_check();
    cyc_adv();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},  16'({bus.gnt0, bus.gnt1}), 16'd0);
    chk({tag, "_cvld"}, 16'({bus.cvld0, bus.cvld1}), 16'd0);
    chk({tag, "_cost"}, 16'(bus.cost_o), 16'd0);
    chk({tag, "_wj"},   16'({bus.W, bus.J}), 16'd0);
  endtask

  initial begin
    int idx0, idx1, c0, c0_sw;
    bit seen_sw;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    chk_all_zero("reset");
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b1;

    // tie from reset, then switch tagging across a no-bubble handover
    drive(1, 1, 2, 0, 1, 3, 4, 0);
    cyc();
    drive(1, 2, 5, 1, 1, 3, 4, 0);
    cyc_check();
    chk("tie_gnt0", 16'(bus.gnt0), 16'd1);
    cyc_adv();
    drive(0, 0, 0, 0, 1, 3, 4, 0);
    cyc_check();
    chk("handover_gnt1", 16'(bus.gnt1), 16'd1);
    chk("tag_n1_cvld", 16'({bus.cvld0, bus.cvld1}), 16'b10);
    chk("tag_n1_cost", 16'(bus.cost_o), 16'd20);
    cyc_adv();
    drive(0, 0, 0, 0, 1, 5, 1, 1);
    cyc_check();
    chk("tag_n2_cvld", 16'({bus.cvld0, bus.cvld1}), 16'b01);
    chk("tag_n2_cost", 16'(bus.cost_o), 16'd30);
    cyc_adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    cyc();

    // single requester burst of 8 with last on the 8th
    drive(1, 0, 7, 0, 0, 0, 0, 0);
    cyc();
    for (int i = 0; i < 8; i++) begin
      drive(1, i, 7, i == 7, 0, 0, 0, 0);
      cyc_check();
      chk("single_gnt0", 16'(bus.gnt0), 16'd1);
      if (i > 0) chk("single_cost", 16'(bus.cost_o), 16'((i - 1) * 10));
      cyc_adv();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc_check();
    chk("single_cost_last", 16'(bus.cost_o), 16'd70);
    chk("single_idle", 16'(bus.gnt0), 16'd0);
    cyc_adv();
    cyc_check();
    chk("cost_hold", 16'(bus.cost_o), 16'd70);
    cyc_adv();

    // burst limit: requester 0 wants 20 lookups, requester 1 waits
    rom_mix = 1'b1;
    idx0 = 0; idx1 = 0; c0 = 0; seen_sw = 0; c0_sw = -1;
    for (int k = 0; k < 45; k++) begin
      drive(idx0 < 20, idx0 % 8, (idx0 / 8) % 8, 0,
            k >= 1 && idx1 < 3, idx1 + 4, idx1, idx1 == 2);
      cyc_check();
      if (bus.gnt1 && !seen_sw) begin seen_sw = 1; c0_sw = c0; end
      if (bus.gnt0 && bus.req0) c0++;
      if (e_i0) idx0++;
      if (e_i1) idx1++;
      cyc_adv();
    end
    chk("burst_limit_switch", 16'(c0_sw), 16'd8);
    chk("burst_all_done", 16'(c0), 16'd20);

    // reset asserted during the 4th lookup of a requester-1 burst
    drive(0, 0, 0, 0, 1, 1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 1, k + 1, 2, 0);
      cyc();
    end
    drive(0, 0, 0, 0, 1, 6, 6, 0);
    #2;
    RST = 1'b0;
    #1;
    chk_all_zero("midrst");
    model_reset();
    @(posedge CLK); #1;
    RST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    drive(1, 2, 2, 0, 1, 3, 3, 0);
    cyc();
    cyc_check();
    chk("rst_tie_gnt0", 16'(bus.gnt0), 16'd1);
    cyc_adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    cyc();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      drive($urandom % 4 != 0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom % 4 == 0,
            $urandom % 3 != 0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom % 5 == 0);
      cyc();
    end

`ifdef COST_ARB_STATS_EN
    RST = 1'b0;
    model_reset();
    @(posedge CLK); #1;
    RST = 1'b1;
    drive(0, 0, 0, 0, 1, 3, 3, 0);
    for (int k = 0; k < 70001; k++) @(posedge CLK);
    #1;
    chk("stats_lk1_sat", lk_cnt1, 16'hFFFF);
    chk("stats_lk0_zero", lk_cnt0, 16'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cost_arb.md
COST_ARB -- requirements
Module: cost_arb

Interface
REQ-001 SHALL have parameter MAX_BURST, default 8, meaning the lookups per grant after which the grant is forced to rotate if the other requester is waiting; legal range 1..15.
REQ-002 SHALL have port CLK, input, 1, the single clock; all logic is on the rising edge.
REQ-003 SHALL have port RST, input, 1, the reset; it is asynchronous and active-low.
REQ-004 SHALL have ports req0/req1, input, 1 each, asserted when the requester presents a lookup this cycle.
REQ-005 SHALL have ports W0/W1 and J0/J1, input, 3 each, the worker and job index of each requester.
REQ-006 SHALL have ports last0/last1, input, 1 each, marking the final lookup of a burst; valid only with req.
REQ-007 SHALL have ports gnt0/gnt1, output, 1 each, registered grant; at most one is high.
REQ-008 SHALL have ports cvld0/cvld1, output, 1 each, asserted when the returned cost belongs to that requester.
REQ-009 SHALL have port cost_o, output, 7, the returned cost, shared by both requesters and qualified by cvld0/cvld1.
REQ-010 SHALL have ports W/J, output, 3 each, the cost ROM address.
REQ-011 SHALL have port Cost, input, 7, the ROM data, valid one cycle after W/J are presented.

Function
REQ-012 SHALL use the FSM states IDLE, OWN0 and OWN1; gnt0 is high exactly in OWN0 and gnt1 exactly in OWN1.
REQ-013 In IDLE, SHALL go to OWNx next cycle if only reqx is high; if both are high, SHALL pick the requester not served last (rr pointer).
REQ-014 A lookup is issued in any cycle with gntx&reqx; W/J SHALL be driven combinationally from requester x in that cycle, and W=J=0 otherwise.
REQ-015 For a lookup issued in cycle n, SHALL assert cvldx and cost_o=Cost in cycle n+1, tagged by a registered owner so a grant switch at n cannot mis-tag the data.
REQ-016 A burst SHALL end on any of:
  - a lookup with lastx=1;
  - reqx low while granted;
  - the MAX_BURST-th lookup while the other requester's req is high.
REQ-017 At burst end, SHALL go directly to OWN(other) if the other requester's req is high (no bubble cycle), else to IDLE; the rr pointer SHALL update to the requester just served.
REQ-018 SHALL keep a 4-bit burst counter, cleared on grant entry and incremented per lookup.
REQ-019 If the burst counter reaches MAX_BURST with no competing req, SHALL clear the counter and keep the grant.
REQ-020 SHALL ignore reqx while gntx is low; such a cycle issues no lookup and produces no cvld.
REQ-021 cost_o SHALL hold its last value when cvld0 and cvld1 are both low.

Reset
REQ-022 Asserting RST (low) SHALL immediately force IDLE and clear gnt0, gnt1, cvld0, cvld1, cost_o, W, J, the burst counter, owner and rr pointer (requester 0 wins the first tie).
REQ-023 A lookup in flight when RST asserts SHALL be discarded; no cvld follows release.

Configuration
REQ-024 With macro COST_ARB_STATS_EN defined, SHALL add output ports lk_cnt0/lk_cnt1 (16 bits each), counting issued lookups per requester, saturating at 16'hFFFF and cleared by reset.
REQ-025 Without COST_ARB_STATS_EN, these ports and counters SHALL be absent, with otherwise identical behaviour.

Structure
REQ-026 A shared package SHALL hold the FSM state typedef (IDLE/OWN0/OWN1), the ROM width constants (index 3, cost 7) and the MAX_BURST default.
REQ-027 SHALL contain one sub-module, cost_arb_rr, holding the rr pointer and tie-break logic; the rest is flat.

Verification
REQ-028 Single requester: req0 held for 8 cycles, W0=0..7, J0=7, last0 on the 8th, ROM Cost=W*10 -> gnt0 one cycle after req0, cvld0 for 8 cycles with cost_o=0,10,...,70, then IDLE.
REQ-029 Tie from reset: req0 and req1 rise together -> gnt0 first; after last0, gnt1 in the very next cycle with no idle cycle.
REQ-030 Burst limit: MAX_BURST=8, req0 holds 20 lookups with no last, req1 waiting -> rotation to gnt1 after the 8th lookup; the 9th lookup of req0 waits.
REQ-031 Switch tagging: the last lookup of requester 0 in cycle n and the first of requester 1 in cycle n+1 -> cvld0 only in n+1, cvld1 only in n+2, with correct costs.
REQ-032 Reset mid-burst: RST low during the 4th lookup of a burst -> all outputs 0 in the same cycle, no cvld after release, and the next tie goes to requester 0.
REQ-033 Stats (COST_ARB_STATS_EN defined): 70000 lookups on requester 1 -> lk_cnt1=16'hFFFF, lk_cnt0=0.
